// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared definitions for the memory port arbiter. Contains the
//               arbiter state encoding, the default NOP instruction, the
//               default timeout and a helper that sizes the timeout counter.
//               The optional timeout feature is enabled by MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter step sequencing states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DREQ    = 3'd1,
    GAP     = 3'd2,
    FREQ    = 3'd3,
    RELEASE = 3'd4
  } arb_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSN_DEFAULT       = 32'h0000_0013;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  // Bits needed to count from 0 up to and including limit
  function automatic int unsigned timeout_cnt_w(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_counter
// Description : Wait counter for one memory access. Cleared while no access
//               is in progress, counts cycles without acknowledge and flags
//               expiry on the cycle the count would reach LIMIT, so the access
//               is abandoned after exactly LIMIT unacknowledged cycles.
//               Used by mem_port_arbiter only when MEM_TIMEOUT_EN is defined.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               clear       - hold the count at zero
//               enable      - count this cycle (access pending, no ack)
//               expired     - LIMIT unacknowledged cycles reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned CNT_W = timeout_cnt_w(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is flagged as the count steps onto LIMIT, so the FSM leaves the
  // access state on the same edge.
  assign expired = enable && (count_q == CNT_W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               data access. Each core step performs at most one data access
//               followed by one fetch, with a one-cycle idle gap between them,
//               and holds stall high until both finish; stall then drops for
//               exactly one cycle. Optional access timeout: MEM_TIMEOUT_EN.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               pc_f                  - fetch address
//               d_addr/d_wdata        - data address / store data
//               d_we/d_re             - store / load request
//               inst_f/read_data_m    - registered instruction / load data
//               stall                 - core stall, low only in RELEASE
//               mem_req/mem_we        - memory request / write strobe
//               mem_addr/mem_wdata    - memory address / write data
//               mem_rdata/mem_ack     - memory read data / done
//               err                   - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 32,
  parameter int unsigned        DATA_W         = 32,
  parameter logic [DATA_W-1:0]  NOP_INSN       = DATA_W'(NOP_INSN_DEFAULT),
  parameter int unsigned        TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_f,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  input  logic              d_re,
  output logic [DATA_W-1:0] inst_f,
  output logic [DATA_W-1:0] read_data_m,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  arb_state_e        state_q,     state_d;
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q,    mem_we_d;
  logic [DATA_W-1:0] inst_f_q,    inst_f_d;
  logic [DATA_W-1:0] rdata_m_q,   rdata_m_d;
  logic              stall_q,     stall_d;
  logic              err_q,       err_d;

  logic w_timeout;
  logic w_done;
  logic w_abort;

`ifdef MEM_TIMEOUT_EN
  logic w_in_access;

  assign w_in_access = (state_q == DREQ) || (state_q == FREQ);

  // The gap/idle state between any two accesses clears the count, which
  // gives each access a fresh budget on entry.
  mem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!w_in_access),
    .enable  (w_in_access && !mem_ack),
    .expired (w_timeout)
  );
`else
  // Without the timeout the limit has no effect and this folds to zero.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // An ack always wins over a coincident expiry.
  assign w_done  = mem_ack || w_timeout;
  assign w_abort = w_timeout && !mem_ack;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    inst_f_d    = inst_f_q;
    rdata_m_d   = rdata_m_q;
    stall_d     = 1'b1;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        // Snapshot the step's request; the memory-side registers then hold
        // it stable for the whole access.
        pc_d = pc_f;
        if (d_we || d_re) begin
          state_d     = DREQ;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we;
        end else begin
          state_d    = FREQ;
          mem_addr_d = pc_f;
        end
      end

      DREQ: begin
        if (w_done) begin
          state_d  = GAP;
          mem_we_d = 1'b0;
          // A store (including we and re together) returns zero.
          rdata_m_d = (mem_we_q || w_abort) ? '0 : mem_rdata;
          err_d     = err_q || w_abort;
        end
      end

      GAP: begin
        state_d    = FREQ;
        mem_addr_d = pc_q;
      end

      FREQ: begin
        if (w_done) begin
          state_d  = RELEASE;
          stall_d  = 1'b0;
          inst_f_d = w_abort ? NOP_INSN : mem_rdata;
          err_d    = err_q || w_abort;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      inst_f_q    <= NOP_INSN;
      rdata_m_q   <= '0;
      stall_q     <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      inst_f_q    <= inst_f_d;
      rdata_m_q   <= rdata_m_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

  assign mem_req     = (state_q == DREQ) || (state_q == FREQ);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign inst_f      = inst_f_q;
  assign read_data_m = rdata_m_q;
  assign stall       = stall_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. Drives
//               core steps cycle by cycle, plays the memory side (ack/rdata)
//               and compares outputs against hand-computed expectations.
//               Timeout scenario is built when MEM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f, d_addr, d_wdata;
  logic        d_we, d_re;
  logic [31:0] inst_f, read_data_m;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .NOP_INSN       (NOP),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_f        (pc_f),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_we        (d_we),
    .d_re        (d_re),
    .inst_f      (inst_f),
    .read_data_m (read_data_m),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full core step starting in IDLE. Data/fetch ack after dwait/fwait
  // extra cycles; exp_rd/exp_insn are what the core must see in RELEASE.
  task automatic run_step(input logic [31:0] pc, input logic [31:0] da,
                          input logic [31:0] wd, input logic we, input logic re,
                          input int dwait, input logic [31:0] drd,
                          input int fwait, input logic [31:0] frd,
                          input logic [31:0] exp_rd, input logic [31:0] exp_insn);
    pc_f = pc; d_addr = da; d_wdata = wd; d_we = we; d_re = re;
    mem_ack = 1'b0; mem_rdata = JUNK;
    check("idle_stall", stall, 1);
    check("idle_req", mem_req, 0);
    step();
    // Later changes within the step must not leak into the access
    pc_f = ~pc; d_addr = ~da; d_wdata = ~wd; d_we = 1'b0; d_re = 1'b0;
    if (we || re) begin
      for (int i = 0; i <= dwait; i++) begin
        check("dreq_req", mem_req, 1);
        check("dreq_addr", mem_addr, da);
        check("dreq_we", mem_we, we);
        if (we) check("dreq_wdata", mem_wdata, wd);
        check("dreq_stall", stall, 1);
        if (i == dwait) begin
          mem_ack = 1'b1; mem_rdata = drd;
        end
        step();
        mem_ack = 1'b0; mem_rdata = JUNK;
      end
      check("gap_req", mem_req, 0);
      check("gap_we", mem_we, 0);
      check("gap_stall", stall, 1);
      step();
    end
    for (int i = 0; i <= fwait; i++) begin
      check("freq_req", mem_req, 1);
      check("freq_addr", mem_addr, pc);
      check("freq_we", mem_we, 0);
      check("freq_stall", stall, 1);
      if (i == fwait) begin
        mem_ack = 1'b1; mem_rdata = frd;
      end
      step();
      mem_ack = 1'b0; mem_rdata = JUNK;
    end
    check("rel_stall", stall, 0);
    check("rel_req", mem_req, 0);
    check("rel_insn", inst_f, exp_insn);
    check("rel_rdata", read_data_m, exp_rd);
    step();
    check("after_rel_stall", stall, 1);
    check("after_rel_insn", inst_f, exp_insn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pc_f = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_re = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;

    // Reset held three cycles
    repeat (3) step();
    check("rst_stall", stall, 1);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_insn", inst_f, NOP);
    check("rst_rdata", read_data_m, 0);
    check("rst_err", err, 0);
    reset = 1'b0;

    // Fetch only, zero-wait: IDLE, FREQ, RELEASE
    run_step(32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 0, JUNK, 0, 32'h0050_0093,
             32'h0, 32'h0050_0093);

    // Load with ack on the 4th DREQ cycle
    run_step(32'h48, 32'h200, 32'h0, 1'b0, 1'b1, 3, 32'hDEAD_BEEF, 0, 32'h00A0_0113,
             32'hDEAD_BEEF, 32'h00A0_0113);

    // Store, zero-wait: five-cycle step, load data returns to zero
    run_step(32'h44, 32'd100, 32'd25, 1'b1, 1'b0, 0, 32'h5555_5555, 0, 32'h0010_0193,
             32'h0, 32'h0010_0193);

    // Load with delayed fetch, then store+load together behaves as a store
    run_step(32'h4C, 32'h300, 32'h0, 1'b0, 1'b1, 0, 32'h1234_5678, 2, 32'h0020_0213,
             32'h1234_5678, 32'h0020_0213);
    run_step(32'h50, 32'h304, 32'hCAFE_0001, 1'b1, 1'b1, 1, 32'h7777_7777, 0, 32'h0030_0293,
             32'h0, 32'h0030_0293);

    // Reset during a fetch
    pc_f = 32'h80; d_we = 1'b0; d_re = 1'b0; mem_ack = 1'b0;
    step();
    check("pre_rst_req", mem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_req", mem_req, 0);
    check("midrst_stall", stall, 1);
    check("midrst_insn", inst_f, NOP);
    check("midrst_rdata", read_data_m, 0);
    // Back in IDLE: a fresh fetch-only step runs from here
    run_step(32'h84, 32'h0, 32'h0, 1'b0, 1'b0, 0, JUNK, 0, 32'h0040_0313,
             32'h0, 32'h0040_0313);
    check("err_clear", err, 0);

`ifdef MEM_TIMEOUT_EN
    // Fetch never acknowledged: abandoned after TB_TIMEOUT request cycles
    pc_f = 32'hC0; d_we = 1'b0; d_re = 1'b0; mem_ack = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      check("to_req", mem_req, 1);
      check("to_stall", stall, 1);
      step();
    end
    check("to_rel_req", mem_req, 0);
    check("to_rel_stall", stall, 0);
    check("to_err", err, 1);
    check("to_insn", inst_f, NOP);
    step();
    check("to_after_stall", stall, 1);
    check("to_err_sticky", err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
